// File: rtl/stream_mux_n.sv
// N-channel valid/ready stream multiplexer with a single registered output stage.
// Channels are selected either by a software index or by round-robin arbitration.
module stream_mux_n #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic             mode,
  input  logic [SW-1:0]    sel,
  output logic [WIDTH-1:0] out_data,
  output logic [SW-1:0]    out_chan,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);

  logic [WIDTH-1:0] chan_data [N];
  logic [N-1:0]     upper_mask;
  logic [N-1:0]     sel_hit;
  logic [N-1:0]     grant_oh;

  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic [SW-1:0]    out_chan_reg, out_chan_next;
  logic             out_valid_reg, out_valid_next;
  logic [SW-1:0]    ptr_reg, ptr_next;

  logic             load;
  logic [N-1:0]     upper_valid;
  logic [N-1:0]     scan_vec;
  logic [SW-1:0]    rr_idx;
  logic             rr_any;
  logic             fixed_hit;
  logic [SW-1:0]    grant;
  logic             grant_valid;
  logic [WIDTH-1:0] mux_data;

  // Per-channel slicing, pointer mask and one-hot decode of the grant.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign chan_data[gi]  = in_data[gi*WIDTH +: WIDTH];
      assign upper_mask[gi] = (SW'(gi) >= ptr_reg);
      assign sel_hit[gi]    = in_valid[gi] && (sel == SW'(gi));
      assign grant_oh[gi]   = grant_valid && (grant == SW'(gi));
      assign in_ready[gi]   = load && grant_oh[gi];
    end
  endgenerate

  assign load = !out_valid_reg || out_ready;

  // Round-robin: lowest valid index at or above ptr, else wrap to lowest valid overall.
  always_comb begin
    upper_valid = in_valid & upper_mask;
    scan_vec    = (|upper_valid) ? upper_valid : in_valid;
    rr_any      = |in_valid;
    rr_idx      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (scan_vec[i]) begin
        rr_idx = SW'(i);
      end
    end
  end

  // An out-of-range sel matches no channel, so it naturally yields no grant.
  assign fixed_hit   = |sel_hit;
  assign grant       = mode ? rr_idx : sel;
  assign grant_valid = !rst && (mode ? rr_any : fixed_hit);

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_oh[i]) begin
        mux_data = mux_data | chan_data[i];
      end
    end
  end

  always_comb begin
    out_data_next  = out_data_reg;
    out_chan_next  = out_chan_reg;
    out_valid_next = out_valid_reg;
    ptr_next       = ptr_reg;
    if (load) begin
      if (grant_valid) begin
        out_data_next  = mux_data;
        out_chan_next  = grant;
        out_valid_next = 1'b1;
        if (mode) begin
          ptr_next = (grant == LAST_IDX) ? '0 : grant + SW'(1);
        end
      end else begin
        out_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= '0;
    end else begin
      out_data_reg  <= out_data_next;
      out_chan_reg  <= out_chan_next;
      out_valid_reg <= out_valid_next;
      ptr_reg       <= ptr_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_chan  = out_chan_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n (N=4, WIDTH=8): directed vector table followed by
// randomized traffic checked against a behavioural arbitration model.
module tb_stream_mux_n;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic            clk;
  logic            rst;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_chan;
  logic            out_valid;
  logic            out_ready;

  int checks;
  int failures;

  stream_mux_n #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic        ordy;
    logic [31:0] data;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [1:0]  e_oc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic m, input logic [1:0] s,
                     input logic [3:0] v, input logic o, input logic [31:0] d,
                     input logic [3:0] er, input logic eov, input logic [7:0] eod,
                     input logic [1:0] eoc);
    vec_t x;
    x.rst = r; x.mode = m; x.sel = s; x.valid = v; x.ordy = o; x.data = d;
    x.e_rdy = er; x.e_ov = eov; x.e_od = eod; x.e_oc = eoc;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  // Behavioural model: output register plus rotating priority pointer.
  logic        m_ov;
  logic [7:0]  m_od;
  int          m_oc;
  int          m_ptr;

  task automatic model_grant(output bit gv, output int g);
    gv = 0;
    g  = 0;
    if (!mode) begin
      if (int'(sel) < N && in_valid[sel]) begin
        gv = 1;
        g  = int'(sel);
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!gv && in_valid[idx]) begin
          gv = 1;
          g  = idx;
        end
      end
    end
    if (rst) gv = 0;
  endtask

  task automatic drive(input logic r, input logic m, input logic [1:0] s,
                       input logic [3:0] v, input logic o, input logic [31:0] d);
    rst = r; mode = m; sel = s; in_valid = v; out_ready = o; in_data = d;
  endtask

  initial begin
    logic [31:0] R, F, B;
    checks = 0;
    failures = 0;
    R = 32'h13121110;
    F = 32'h44A52211;
    B = 32'h77663355;

    // reset with all channels valid
    add(1, 1, 0, 4'hF, 1, R, 4'b0000, 0, 8'h00, 0);
    add(1, 1, 0, 4'hF, 1, R, 4'b0000, 0, 8'h00, 0);
    // fixed select ch2
    add(0, 0, 2, 4'hF, 1, F, 4'b0100, 1, 8'hA5, 2);
    add(0, 0, 2, 4'hF, 1, F, 4'b0100, 1, 8'hA5, 2);
    add(0, 0, 2, 4'hF, 1, F, 4'b0100, 1, 8'hA5, 2);
    // round-robin full load, ptr still 0
    add(0, 1, 0, 4'hF, 1, R, 4'b0001, 1, 8'h10, 0);
    add(0, 1, 0, 4'hF, 1, R, 4'b0010, 1, 8'h11, 1);
    add(0, 1, 0, 4'hF, 1, R, 4'b0100, 1, 8'h12, 2);
    add(0, 1, 0, 4'hF, 1, R, 4'b1000, 1, 8'h13, 3);
    add(0, 1, 0, 4'hF, 1, R, 4'b0001, 1, 8'h10, 0);
    add(0, 1, 0, 4'hF, 1, R, 4'b0010, 1, 8'h11, 1);
    // ptr=2, only ch0 valid -> ptr becomes 1
    add(0, 1, 0, 4'b0001, 1, R, 4'b0001, 1, 8'h10, 0);
    // skip: ch0 and ch3 valid from ptr=1
    add(0, 1, 0, 4'b1001, 1, R, 4'b1000, 1, 8'h13, 3);
    add(0, 1, 0, 4'b1001, 1, R, 4'b0001, 1, 8'h10, 0);
    add(0, 1, 0, 4'b1001, 1, R, 4'b1000, 1, 8'h13, 3);
    // back-pressure on beat 0x33
    add(0, 0, 1, 4'hF, 1, B, 4'b0010, 1, 8'h33, 1);
    add(0, 1, 0, 4'b1010, 0, R, 4'b0000, 1, 8'h33, 1);
    add(0, 0, 3, 4'b0111, 0, F, 4'b0000, 1, 8'h33, 1);
    add(0, 1, 2, 4'b1100, 0, 32'hDEADBEEF, 4'b0000, 1, 8'h33, 1);
    add(0, 0, 2, 4'hF, 1, F, 4'b0100, 1, 8'hA5, 2);
    // mid-stream reset, then idle
    add(1, 1, 0, 4'hF, 1, R, 4'b0000, 0, 8'h00, 0);
    add(0, 1, 0, 4'b0000, 1, R, 4'b0000, 0, 8'h00, 0);
    add(0, 1, 0, 4'hF, 1, R, 4'b0001, 1, 8'h10, 0);
    // no grant with load: valid drops, data/chan hold
    add(0, 1, 0, 4'b0000, 1, R, 4'b0000, 0, 8'h10, 0);
    // empty register loads even with out_ready low, then holds
    add(0, 0, 2, 4'b0100, 0, F, 4'b0100, 1, 8'hA5, 2);
    add(0, 0, 2, 4'b0100, 0, F, 4'b0000, 1, 8'hA5, 2);
    // mode 0 transfers left ptr at 1
    add(0, 1, 0, 4'hF, 1, R, 4'b0010, 1, 8'h11, 1);

    drive(1, 0, 0, 4'h0, 0, 32'h0);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].ordy, vecs[i].data);
      #3;
      chk("in_ready", i, 32'(in_ready), 32'(vecs[i].e_rdy));
      @(posedge clk);
      #1;
      chk("out_valid", i, 32'(out_valid), 32'(vecs[i].e_ov));
      chk("out_data", i, 32'(out_data), 32'(vecs[i].e_od));
      chk("out_chan", i, 32'(out_chan), 32'(vecs[i].e_oc));
      $display("vec %0d rst=%0b mode=%0b sel=%0d valid=%b ordy=%0b -> rdy=%b ov=%0b data=%02h chan=%0d",
               i, rst, mode, sel, in_valid, out_ready, in_ready, out_valid, out_data, out_chan);
    end

    m_ov = 0; m_od = '0; m_oc = 0; m_ptr = 0;
    for (int t = 0; t < 400; t++) begin
      bit gv;
      int g;
      logic [3:0] exp_rdy;
      bit ld;
      drive((t == 0) || ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0, $urandom);
      ld = !m_ov || out_ready;
      model_grant(gv, g);
      exp_rdy = (ld && gv) ? 4'(1 << g) : 4'b0000;
      #3;
      chk("rand_in_ready", t, 32'(in_ready), 32'(exp_rdy));
      @(posedge clk);
      if (rst) begin
        m_ov = 0; m_od = '0; m_oc = 0; m_ptr = 0;
      end else if (ld) begin
        if (gv) begin
          m_ov = 1;
          m_od = in_data[g*W +: W];
          m_oc = g;
          if (mode) m_ptr = (g + 1) % N;
        end else begin
          m_ov = 0;
        end
      end
      #1;
      chk("rand_out_valid", t, 32'(out_valid), 32'(m_ov));
      chk("rand_out_data", t, 32'(out_data), 32'(m_od));
      chk("rand_out_chan", t, 32'(out_chan), 32'(m_oc));
      $display("rnd %0d rst=%0b mode=%0b sel=%0d valid=%b ordy=%0b -> rdy=%b ov=%0b data=%02h chan=%0d",
               t, rst, mode, sel, in_valid, out_ready, in_ready, out_valid, out_data, out_chan);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
